// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI bit-reversal stream slave.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam bit EDGE_RISE = 1'b0;
    localparam bit EDGE_FALL = 1'b1;

    // Sample edge is the rising edge exactly when CPOL and CPHA agree.
    function automatic bit sample_edge(input bit cpol, input bit cpha);
        return (cpol ^ cpha) ? EDGE_FALL : EDGE_RISE;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[w-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a history flop for rise/fall detection.
module spi_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~hist_q;
    assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_bitrev_stream.sv
// SPI slave returning each received word bit-reversed during the next word.
module spi_bitrev_stream
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              word_valid,
    output logic [DATA_W-1:0] word_data,
    output logic [CNT_W-1:0]  word_count,
    output logic              frame_err
);

    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam bit SAMPLE_SEL = sample_edge(CPOL, CPHA);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic sample_ev, shift_ev, mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck (
        .clock (clock),
        .resetn(resetn),
        .din   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clock (clock),
        .resetn(resetn),
        .din   (ss),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sample_ev   = (SAMPLE_SEL == EDGE_FALL) ? sck_fall : sck_rise;
    assign shift_ev    = (SAMPLE_SEL == EDGE_FALL) ? sck_rise : sck_fall;

    state_e              state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:1]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   tx_word_q, tx_word_d;
    logic                load_q, load_d;
    logic                miso_q, miso_d;
    logic                word_valid_q, word_valid_d;
    logic [DATA_W-1:0]   word_data_q, word_data_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                frame_err_q, frame_err_d;
    logic [DATA_W-1:0]   rx_word;

    assign rx_word = {mosi_s, rx_shift_q};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        tx_word_d    = tx_word_q;
        load_d       = load_q;
        miso_d       = miso_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_count_d = word_count_q;
        frame_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                miso_d    = 1'b1;
                bit_cnt_d = '0;
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = '1;
                    load_d     = 1'b0;
                end
            end
            ACTIVE: begin
                // ss release takes priority over any coincident sck edge
                if (ss_rise) begin
                    state_d     = IDLE;
                    miso_d      = 1'b1;
                    load_d      = 1'b0;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sample_ev) begin
                    rx_shift_d = rx_word[DATA_W-1:1];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d    = '0;
                        word_data_d  = rx_word;
                        word_valid_d = 1'b1;
                        word_count_d = word_count_q + 1'b1;
                        tx_word_d    = rx_word;
                        load_d       = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (shift_ev) begin
                    if (load_q) begin
                        miso_d     = tx_word_q[DATA_W-1];
                        tx_shift_d = {tx_word_q[DATA_W-2:0], 1'b0};
                        load_d     = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b1};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mosi_sync_q  <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            tx_word_q    <= '0;
            load_q       <= 1'b0;
            miso_q       <= 1'b1;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_word_q    <= tx_word_d;
            load_q       <= load_d;
            miso_q       <= miso_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign miso       = miso_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_count = word_count_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_bitrev_stream.sv
// Directed bench: mode 0 / mode 3 byte slaves and a 16-bit slave with 2-bit count.
module tb_spi_bitrev_stream;

    localparam int HALF = 80;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0] resetn = 3'b000;
    logic [2:0] sck    = 3'b010;
    logic [2:0] ss     = 3'b111;
    logic [2:0] mosi   = 3'b000;

    logic        miso0, wv0, fe0;
    logic [7:0]  data0;
    logic [15:0] cnt0;
    logic        miso1, wv1, fe1;
    logic [7:0]  data1;
    logic [15:0] cnt1;
    logic        miso2, wv2, fe2;
    logic [15:0] data2;
    logic [1:0]  cnt2;

    spi_bitrev_stream #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clock(clock), .resetn(resetn[0]), .sck(sck[0]), .ss(ss[0]),
        .mosi(mosi[0]), .miso(miso0), .word_valid(wv0), .word_data(data0),
        .word_count(cnt0), .frame_err(fe0)
    );

    spi_bitrev_stream #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clock(clock), .resetn(resetn[1]), .sck(sck[1]), .ss(ss[1]),
        .mosi(mosi[1]), .miso(miso1), .word_valid(wv1), .word_data(data1),
        .word_count(cnt1), .frame_err(fe1)
    );

    spi_bitrev_stream #(.DATA_W(16), .CNT_W(2)) u_w16 (
        .clock(clock), .resetn(resetn[2]), .sck(sck[2]), .ss(ss[2]),
        .mosi(mosi[2]), .miso(miso2), .word_valid(wv2), .word_data(data2),
        .word_count(cnt2), .frame_err(fe2)
    );

    int nwv0 = 0, nfe0 = 0, nwv1 = 0, nwv2 = 0, nfe2 = 0;
    always @(posedge clock) begin
        if (wv0) nwv0 <= nwv0 + 1;
        if (fe0) nfe0 <= nfe0 + 1;
        if (wv1) nwv1 <= nwv1 + 1;
        if (wv2) nwv2 <= nwv2 + 1;
        if (fe2) nfe2 <= nfe2 + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic miso_of(input int d);
        case (d)
            0: return miso0;
            1: return miso1;
            default: return miso2;
        endcase
    endfunction

    task automatic frame_begin(input int d);
        ss[d] = 1'b0;
        #HALF;
    endtask

    task automatic frame_end(input int d);
        #HALF;
        ss[d] = 1'b1;
        #(4*HALF);
    endtask

    // Master side, LSB first; dut 1 is mode 3, the others mode 0.
    task automatic xfer(input int d, input int nb, input logic [31:0] tx,
                        output logic [31:0] rx);
        logic cp;
        cp = (d == 1);
        rx = '0;
        for (int i = 0; i < nb; i++) begin
            if (!cp) begin
                mosi[d] = tx[i];
                #HALF;
                rx[i] = miso_of(d);
                sck[d] = 1'b1;
                #HALF;
                sck[d] = 1'b0;
            end else begin
                #HALF;
                sck[d] = 1'b0;
                mosi[d] = tx[i];
                #HALF;
                rx[i] = miso_of(d);
                sck[d] = 1'b1;
            end
        end
    endtask

    logic [31:0] rx;
    int s_wv, s_fe;

    initial begin
        #23;
        check("rst_miso", miso0, 1);
        check("rst_wv", wv0, 0);
        check("rst_data", data0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_ferr", fe0, 0);
        resetn = 3'b111;
        #HALF;

        // mode 0: 0x01, 0x00
        s_wv = nwv0;
        frame_begin(0);
        xfer(0, 8, 32'h01, rx);
        check("m0_rx0", rx, 32'hFF);
        check("m0_data0", data0, 8'h01);
        xfer(0, 8, 32'h00, rx);
        check("m0_rx1", rx, 32'h80);
        frame_end(0);
        check("m0_data1", data0, 8'h00);
        check("m0_cnt", cnt0, 2);
        check("m0_wv", nwv0 - s_wv, 2);
        check("m0_miso_idle", miso0, 1);

        // mode 3 burst
        frame_begin(1);
        xfer(1, 8, 32'hA5, rx);
        check("m3_rx0", rx, 32'hFF);
        xfer(1, 8, 32'h3C, rx);
        check("m3_rx1", rx, 32'hA5);
        xfer(1, 8, 32'h12, rx);
        check("m3_rx2", rx, 32'h3C);
        xfer(1, 8, 32'h00, rx);
        check("m3_rx3", rx, 32'h48);
        frame_end(1);
        check("m3_cnt", cnt1, 4);
        check("m3_wv", nwv1, 4);
        check("m3_data", data1, 8'h00);
        check("m3_ferr", fe1, 0);

        // partial word of 5 bits
        s_wv = nwv0;
        s_fe = nfe0;
        frame_begin(0);
        xfer(0, 5, 32'h1F, rx);
        frame_end(0);
        check("pe_ferr", nfe0 - s_fe, 1);
        check("pe_wv", nwv0 - s_wv, 0);
        check("pe_cnt", cnt0, 2);
        check("pe_miso", miso0, 1);
        frame_begin(0);
        xfer(0, 8, 32'h5A, rx);
        frame_end(0);
        check("pe_next_rx", rx, 32'hFF);
        check("pe_next_cnt", cnt0, 3);
        check("pe_next_data", data0, 8'h5A);

        // async reset 4 bits into a word
        s_fe = nfe0;
        frame_begin(0);
        xfer(0, 4, 32'h0F, rx);
        resetn[0] = 1'b0;
        #1;
        check("ar_miso", miso0, 1);
        check("ar_wv", wv0, 0);
        check("ar_data", data0, 0);
        check("ar_cnt", cnt0, 0);
        check("ar_ferr", fe0, 0);
        #9;
        ss[0] = 1'b1;
        #HALF;
        resetn[0] = 1'b1;
        #HALF;
        check("ar_no_ferr", nfe0 - s_fe, 0);
        frame_begin(0);
        xfer(0, 8, 32'hC3, rx);
        frame_end(0);
        check("ar_next_rx", rx, 32'hFF);
        check("ar_next_cnt", cnt0, 1);
        check("ar_next_data", data0, 8'hC3);

        // 8th sample edge lands on the same clock as ss release
        s_wv = nwv0;
        s_fe = nfe0;
        frame_begin(0);
        xfer(0, 7, 32'h7F, rx);
        mosi[0] = 1'b1;
        #HALF;
        sck[0] = 1'b1;
        ss[0] = 1'b1;
        #(2*HALF);
        sck[0] = 1'b0;
        #(2*HALF);
        check("co_wv", nwv0 - s_wv, 0);
        check("co_ferr", nfe0 - s_fe, 1);
        check("co_cnt", cnt0, 1);
        check("co_data", data0, 8'hC3);

        // 16-bit words, 2-bit wrapping count
        frame_begin(2);
        xfer(2, 16, 32'h0001, rx);
        check("w16_rx0", rx, 32'hFFFF);
        check("w16_cnt1", cnt2, 1);
        xfer(2, 16, 32'h0002, rx);
        check("w16_rx1", rx, 32'h8000);
        check("w16_cnt2", cnt2, 2);
        xfer(2, 16, 32'h0003, rx);
        check("w16_rx2", rx, 32'h4000);
        check("w16_cnt3", cnt2, 3);
        xfer(2, 16, 32'h0004, rx);
        check("w16_rx3", rx, 32'hC000);
        check("w16_cnt0", cnt2, 0);
        xfer(2, 16, 32'h0005, rx);
        check("w16_rx4", rx, 32'h2000);
        check("w16_cnt1b", cnt2, 1);
        frame_end(2);
        check("w16_wv", nwv2, 5);
        check("w16_data", data2, 16'h0005);
        check("w16_ferr", nfe2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
